// File: rtl/uart_hex_line_formatter.sv
// Latches a block of words on start and sends them to a uart as uppercase hex ASCII:
// words separated by SEPARATOR, line ended with CR LF. Define LINE_NUMBER_EN to prefix a 16-bit line count.
module uart_hex_line_formatter #(
    parameter int          NUMBER_OF_WORDS  = 2,
    parameter int          NYBBLES_PER_WORD = 4,
    parameter logic [7:0]  SEPARATOR        = 8'h20
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic                                            start,
    input  logic [NUMBER_OF_WORDS*NYBBLES_PER_WORD*4-1:0]  data,
    output logic                                            busy,
    output logic                                            done,
    input  logic                                            uart_busy,
    output logic                                            uart_wr,
    output logic [7:0]                                      uart_dat
);
    // state  | meaning
    // IDLE   | waiting for start, busy low
    // LOAD   | present current byte and raise uart_wr
    // STROBE | drop uart_wr
    // GUARD  | one cycle for the uart to raise uart_busy
    // WAIT   | wait for uart_busy low, then next byte or finish

    localparam int DATA_W = NUMBER_OF_WORDS * NYBBLES_PER_WORD * 4;
`ifdef LINE_NUMBER_EN
    localparam int PREFIX_BYTES = 5;
`else
    localparam int PREFIX_BYTES = 0;
`endif
    localparam int TOTAL_BYTES = NUMBER_OF_WORDS * NYBBLES_PER_WORD + (NUMBER_OF_WORDS - 1) + 2 + PREFIX_BYTES;
    localparam int INDEX_W     = $clog2(TOTAL_BYTES + 5);

    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(TOTAL_BYTES - 1);
    localparam logic [INDEX_W-1:0] CR_INDEX   = INDEX_W'(TOTAL_BYTES - 2);
    localparam logic [3:0]         WORD_END   = 4'(NYBBLES_PER_WORD);

    typedef enum logic [2:0] {IDLE, LOAD, STROBE, GUARD, WAIT} state_t;

    state_t               state;
    logic [DATA_W-1:0]    data_reg;
    logic [INDEX_W-1:0]   byte_index;
    logic [3:0]           nybble_count;
    logic [7:0]           current_byte;
    logic                 in_prefix;
    logic                 in_tail;
    logic                 is_last;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

`ifdef LINE_NUMBER_EN
    logic [15:0] line_count;
    logic [15:0] prefix_shift;

    always_comb begin
        prefix_shift = line_count << {byte_index[1:0], 2'b00};
        in_prefix    = (byte_index < INDEX_W'(PREFIX_BYTES));
    end
`else
    always_comb begin
        in_prefix = 1'b0;
    end
`endif

    always_comb begin
        in_tail = (byte_index >= CR_INDEX);
        is_last = (byte_index == LAST_INDEX);
    end

    // The data register shifts left as digits go out, so its top nybble is always the next digit.
    always_comb begin
        current_byte = hex_ascii(data_reg[DATA_W-1 -: 4]);
        if (nybble_count == WORD_END)
            current_byte = SEPARATOR;
`ifdef LINE_NUMBER_EN
        if (in_prefix)
            current_byte = (byte_index == INDEX_W'(4)) ? SEPARATOR : hex_ascii(prefix_shift[15:12]);
`endif
        if (byte_index == CR_INDEX)
            current_byte = 8'h0D;
        if (is_last)
            current_byte = 8'h0A;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            uart_wr      <= 1'b0;
            uart_dat     <= 8'h00;
            data_reg     <= '0;
            byte_index   <= '0;
            nybble_count <= '0;
`ifdef LINE_NUMBER_EN
            line_count   <= 16'h0000;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        data_reg     <= data;
                        busy         <= 1'b1;
                        byte_index   <= '0;
                        nybble_count <= '0;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    uart_dat <= current_byte;
                    uart_wr  <= 1'b1;
                    state    <= STROBE;
                end
                STROBE: begin
                    uart_wr <= 1'b0;
                    state   <= GUARD;
                end
                GUARD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (!uart_busy) begin
                        if (is_last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
`ifdef LINE_NUMBER_EN
                            line_count <= line_count + 16'h0001;
`endif
                        end else begin
                            byte_index <= byte_index + 1'b1;
                            if (!in_prefix && !in_tail) begin
                                if (nybble_count == WORD_END) begin
                                    nybble_count <= '0;
                                end else begin
                                    nybble_count <= nybble_count + 4'd1;
                                    data_reg     <= data_reg << 4;
                                end
                            end
                            state <= LOAD;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_wr <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_line_formatter.sv
// Scoreboard bench for uart_hex_line_formatter with a simple busy-for-20-cycles uart model.
module tb_uart_hex_line_formatter;
    localparam int NW = 2;
    localparam int NY = 4;
    localparam int DW = NW * NY * 4;
`ifdef LINE_NUMBER_EN
    localparam int LINE_BYTES = NW * NY + NW - 1 + 2 + 5;
`else
    localparam int LINE_BYTES = NW * NY + NW - 1 + 2;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] data = '0;
    logic          busy;
    logic          done;
    logic          uart_busy = 1'b0;
    logic          uart_wr;
    logic [7:0]    uart_dat;

    int            checks = 0;
    int            failures = 0;
    int            strobes = 0;
    int            done_count = 0;
    int            busy_cnt = 0;
    logic          stuck = 1'b0;
    logic          hold_arm = 1'b0;
    logic          hold_release = 1'b0;
    logic          prev_wr = 1'b0;
    logic [15:0]   line_no = 16'h0000;
    logic [31:0]   exp_q[$];
    string         hexchars = "0123456789ABCDEF";

    uart_hex_line_formatter #(
        .NUMBER_OF_WORDS(NW),
        .NYBBLES_PER_WORD(NY),
        .SEPARATOR(8'h20)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .data(data),
        .busy(busy),
        .done(done),
        .uart_busy(uart_busy),
        .uart_wr(uart_wr),
        .uart_dat(uart_dat)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] hex_char(input logic [3:0] n);
        return {24'h0, hexchars[n]};
    endfunction

    task automatic push_line(input logic [DW-1:0] d);
`ifdef LINE_NUMBER_EN
        for (int k = 0; k < 4; k++)
            exp_q.push_back(hex_char(line_no[(3 - k) * 4 +: 4]));
        exp_q.push_back(32'h20);
`endif
        for (int w = NW - 1; w >= 0; w--) begin
            for (int n = NY - 1; n >= 0; n--)
                exp_q.push_back(hex_char(d[(w * NY + n) * 4 +: 4]));
            if (w > 0)
                exp_q.push_back(32'h20);
        end
        exp_q.push_back(32'h0D);
        exp_q.push_back(32'h0A);
    endtask

    // uart model and output monitor, all sampled on the falling edge
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clock);
            if (uart_wr) begin
                strobes++;
                check_value("wr_single_cycle", {31'h0, prev_wr}, 32'h0);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h100;
                check_value("byte", {24'h0, uart_dat}, e);
                if (hold_arm)
                    stuck = 1'b1;
                busy_cnt = 20;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            if (hold_release)
                stuck = 1'b0;
            uart_busy = stuck || (busy_cnt > 0);
            prev_wr = uart_wr;
            if (done)
                done_count++;
        end
    end

    task automatic send_line(input logic [DW-1:0] d);
        push_line(d);
        @(negedge clock);
        data  = d;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int limit);
        for (int i = 0; i < limit && strobes < target; i++) begin
            @(negedge clock);
            #1;
        end
        check_value("strobe_reached", {31'h0, strobes >= target}, 32'h1);
    endtask

    task automatic wait_done(input int limit);
        int base;
        base = done_count;
        for (int i = 0; i < limit && done_count == base; i++) begin
            @(negedge clock);
            #1;
        end
        check_value("done_seen", done_count - base, 32'h1);
        repeat (5) @(negedge clock);
        #1;
        check_value("done_once", done_count - base, 32'h1);
        check_value("busy_after", {31'h0, busy}, 32'h0);
        check_value("queue_empty", exp_q.size(), 32'h0);
        line_no = line_no + 16'h1;
    endtask

    initial begin
        int base;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check_value("reset_busy", {31'h0, busy}, 32'h0);
        check_value("reset_done", {31'h0, done}, 32'h0);
        check_value("reset_wr", {31'h0, uart_wr}, 32'h0);
        check_value("reset_dat", {24'h0, uart_dat}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        foreach (exp_q[i]) exp_q.delete();

        // basic lines
        base = strobes;
        send_line(32'h1234ABCD);
        wait_done(2000);
        check_value("line_strobes", strobes - base, LINE_BYTES);
        send_line(32'h0000FFFF);
        wait_done(2000);
        send_line(32'h9A9A0F0F);
        wait_done(2000);

        // start re-pulsed mid-line with different data is ignored
        base = strobes;
        send_line(32'h1234ABCD);
        wait_strobes(base + 3, 500);
        data  = 32'hDEADBEEF;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(2000);
        repeat (100) @(negedge clock);
        #1;
        check_value("restart_strobes", strobes - base, LINE_BYTES);
        check_value("restart_busy", {31'h0, busy}, 32'h0);

        // reset after the third strobe abandons the line
        base = strobes;
        send_line(32'h5555AAAA);
        wait_strobes(base + 3, 500);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        #1;
        check_value("rst_wr", {31'h0, uart_wr}, 32'h0);
        check_value("rst_busy", {31'h0, busy}, 32'h0);
        check_value("rst_done", {31'h0, done}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        line_no = 16'h0000;
        repeat (40) @(negedge clock);
        #1;
        check_value("rst_no_strobes", strobes - base, 32'd3);
        base = strobes;
        send_line(32'h1234ABCD);
        wait_done(2000);
        check_value("fresh_line_strobes", strobes - base, LINE_BYTES);

        // uart_busy stuck high after the first strobe
        base = strobes;
        hold_arm = 1'b1;
        send_line(32'hCAFE0123);
        wait_strobes(base + 1, 500);
        hold_arm = 1'b0;
        repeat (10000) @(negedge clock);
        #1;
        check_value("stuck_strobes", strobes - base, 32'd1);
        check_value("stuck_busy", {31'h0, busy}, 32'h1);
        hold_release = 1'b1;
        @(negedge clock);
        hold_release = 1'b0;
        wait_done(2000);
        check_value("stuck_total", strobes - base, LINE_BYTES);

`ifdef LINE_NUMBER_EN
        // line counter wraps from FFFF to 0000
        @(negedge clock);
        force dut.line_count = 16'hFFFF;
        @(negedge clock);
        release dut.line_count;
        line_no = 16'hFFFF;
        send_line(32'h1234ABCD);
        wait_done(2000);
        send_line(32'h1234ABCD);
        wait_done(2000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
